lift_car_controller: RTL and testbench
======================================

# lift_car_controller

Per-car motion controller that sits directly downstream of the central dispatcher: it accepts floor assignments from the dispatcher plus in-car button calls, keeps a pending-stop mask, and runs the car with a SCAN policy (serve all stops in the current direction, then reverse). It reports car position, direction, door state and a per-stop service pulse back to the dispatcher.

## Interface
- NUM_FLOORS, 11, number of served floors (floors 0..NUM_FLOORS-1; max 16)
- FLOOR_TIME, 4, cycles to travel one floor (≥2)
- DOOR_TIME, 8, cycles the door stays open per stop (≥2)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  dispatcher assignment strobe
- req_floor  input  4  floor assigned when req_valid=1
- car_call  input  NUM_FLOORS  in-car buttons, level, bit per floor
- cur_floor  output  4  current floor
- dir  output  2  00 idle, 11 up, 10 down
- door_open  output  1  door open
- pending  output  NUM_FLOORS  registered stop mask
- served_valid  output  1  one-cycle pulse: a stop was served
- served_floor  output  4  floor served, valid with served_valid

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Pending set: req_valid with req_floor<NUM_FLOORS sets that bit; req_floor≥NUM_FLOORS ignored. car_call[i]=1 sets bit i every cycle it is high.
- Pending clear: only on service (entering DOOR, or door extension).
- Same-cycle set and clear of the bit at cur_floor while serving: clear wins, treated as served.
- any_above / any_below: OR of pending bits strictly above / below cur_floor.
- IDLE: pending[cur_floor] → DOOR; else any_above → MOVE_UP; else any_below → MOVE_DOWN; else stay. Priority in that order.
- MOVE_UP/MOVE_DOWN: travel counter counts 0..FLOOR_TIME-1; on the terminal count cur_floor ±1, counter restarts. On that arrival edge: pending[new floor] → DOOR; else continue if stops remain ahead; else reverse if stops behind; else IDLE.
- Entering DOOR: clear pending[cur_floor], pulse served_valid, served_floor=cur_floor, door counter cleared.
- DOOR: new request/call for cur_floor restarts door counter, clears the bit, pulses served_valid again. At count DOOR_TIME-1: stops ahead in dir → continue; else stops behind → reverse; else IDLE. From IDLE-entered DOOR, dir stays 00 and exit follows IDLE priority.
- cur_floor never passes 0 or NUM_FLOORS-1 (guaranteed by any_above/any_below; assert in bench).

## Timing
- Reset values: state IDLE, cur_floor 0, dir 00, door_open 0, pending 0, served_valid 0, served_floor 0, counters 0.
- Reset mid-travel or mid-door returns immediately to reset values; all pending stops lost.
- Request accepted at edge E0 appears in pending after E0; state leaves IDLE at E1.
- One floor every FLOOR_TIME cycles; door_open high exactly DOOR_TIME cycles per unextended stop.
- dir and door_open registered, change on the same edge as state.
- served_valid high one cycle, the cycle after the edge entering DOOR (or extension).

## Structure
- Package lift_pkg: state enum, dir encoding (DIR_IDLE/UP/DOWN), default NUM_FLOORS, floor width constant; shared with the dispatcher.
- One natural sub-module: lift_stop_scan (combinational any_above/any_below/stop_here from pending and cur_floor).
- Travel and door counters, pending register and FSM in the top module.

## Test plan
- Reset, req_floor=3 at E0 (FLOOR_TIME=4) → MOVE_UP at E1, cur_floor=3 and DOOR at E13, served_floor=3, door_open 8 cycles, then IDLE, pending=0.
- At floor 0 moving to 8, car_call[4] during travel → stops at 4 first, then 8; served order 4,8.
- Car at 5 moving up to 9, request floor 2 mid-travel → serves 9, reverses, serves 2; dir 11→10→00.
- Door open at floor 6, car_call[6] pulsed twice → door extended each time, two extra served pulses, total door time includes restarts.
- req_floor=12 → ignored, pending unchanged, state stays IDLE.
- Reset asserted mid-travel at floor 2 with pending {7} → outputs return to reset values asynchronously, no motion after release.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared lift definitions: car state, direction encoding and floor sizing.
// Also used by the central dispatcher.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 11;
    localparam int MAX_FLOORS     = 16;
    localparam int FLOOR_W        = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR
    } lift_state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b11;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic logic [MAX_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        return MAX_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/lift_stop_scan.sv
// Combinational stop scan: pending stops strictly above/below a floor, and at it.
module lift_stop_scan
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  stop_here
);

    logic [31:0] floor_ext;

    assign floor_ext = 32'(floor);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        stop_here = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (i > floor_ext) any_above = any_above | pending[i];
            if (i < floor_ext) any_below = any_below | pending[i];
            if (i == floor_ext) stop_here = pending[i];
        end
    end

endmodule

// File: rtl/lift_car_controller.sv
// Per-car SCAN motion controller: pending-stop mask, travel/door timing,
// and served-stop reporting back to the dispatcher.
module lift_car_controller
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_TIME = 4,
    parameter int DOOR_TIME  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [3:0]            req_floor,
    input  logic [NUM_FLOORS-1:0] car_call,
    output logic [3:0]            cur_floor,
    output logic [1:0]            dir,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  served_valid,
    output logic [3:0]            served_floor
);

    localparam int TW = $clog2(FLOOR_TIME + 1);
    localparam int DW = $clog2(DOOR_TIME + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TIME - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TIME - 1);

    lift_state_e           state_q, state_d;
    logic [3:0]            cur_floor_q, cur_floor_d;
    logic [1:0]            dir_q, dir_d;
    logic                  door_open_q, door_open_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  served_valid_q, served_valid_d;
    logic [3:0]            served_floor_q, served_floor_d;
    logic [TW-1:0]         travel_q, travel_d;
    logic [DW-1:0]         door_q, door_d;

    logic [NUM_FLOORS-1:0] req_mask, set_mask, clr_mask;
    logic                  moving, going_up, travel_done, down_first;
    logic [3:0]            arrive_floor, scan_floor, serve_floor;
    logic                  serve;
    logic                  any_above, any_below, stop_here;

    always_comb begin
        req_mask = '0;
        if (req_valid && (32'(req_floor) < NUM_FLOORS))
            req_mask = NUM_FLOORS'(floor_bit(req_floor));
    end

    assign set_mask     = req_mask | car_call;
    assign moving       = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign going_up     = (state_q == S_MOVE_UP);
    assign travel_done  = (travel_q == TRAVEL_LAST);
    assign down_first   = (dir_q == DIR_DOWN);
    assign arrive_floor = going_up ? cur_floor_q + 4'd1 : cur_floor_q - 4'd1;
    // On an arrival edge the scan must judge the floor being entered, not the one left.
    assign scan_floor   = (moving && travel_done) ? arrive_floor : cur_floor_q;

    lift_stop_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
        .pending   (pending_q),
        .floor     (scan_floor),
        .any_above (any_above),
        .any_below (any_below),
        .stop_here (stop_here)
    );

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        cur_floor_d    = cur_floor_q;
        travel_d       = '0;
        door_d         = '0;
        serve          = 1'b0;
        serve_floor    = cur_floor_q;
        clr_mask       = '0;
        served_valid_d = 1'b0;
        served_floor_d = served_floor_q;

        unique case (state_q)
            S_IDLE: begin
                if (stop_here) begin
                    serve = 1'b1;
                end else if (any_above) begin
                    state_d = S_MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (any_below) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (!travel_done) begin
                    travel_d = travel_q + 1'b1;
                end else begin
                    cur_floor_d = arrive_floor;
                    if (stop_here) begin
                        serve       = 1'b1;
                        serve_floor = arrive_floor;
                    end else if (going_up ? any_above : any_below) begin
                        state_d = state_q;
                    end else if (going_up ? any_below : any_above) begin
                        state_d = going_up ? S_MOVE_DOWN : S_MOVE_UP;
                        dir_d   = going_up ? DIR_DOWN : DIR_UP;
                    end else begin
                        state_d = S_IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // Idle-entered doors carry DIR_IDLE, which shares the up-first priority.
                if (set_mask[cur_floor_q]) begin
                    serve = 1'b1;
                end else if (door_q != DOOR_LAST) begin
                    door_d = door_q + 1'b1;
                end else if (down_first ? any_below : any_above) begin
                    state_d = down_first ? S_MOVE_DOWN : S_MOVE_UP;
                    dir_d   = down_first ? DIR_DOWN : DIR_UP;
                end else if (down_first ? any_above : any_below) begin
                    state_d = down_first ? S_MOVE_UP : S_MOVE_DOWN;
                    dir_d   = down_first ? DIR_UP : DIR_DOWN;
                end else begin
                    state_d = S_IDLE;
                    dir_d   = DIR_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dir_d   = DIR_IDLE;
            end
        endcase

        if (serve) begin
            state_d        = S_DOOR;
            clr_mask       = NUM_FLOORS'(floor_bit(serve_floor));
            served_valid_d = 1'b1;
            served_floor_d = serve_floor;
            door_d         = '0;
        end

        pending_d   = (pending_q | set_mask) & ~clr_mask;
        door_open_d = (state_d == S_DOOR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cur_floor_q    <= '0;
            dir_q          <= DIR_IDLE;
            door_open_q    <= 1'b0;
            pending_q      <= '0;
            served_valid_q <= 1'b0;
            served_floor_q <= '0;
            travel_q       <= '0;
            door_q         <= '0;
        end else begin
            state_q        <= state_d;
            cur_floor_q    <= cur_floor_d;
            dir_q          <= dir_d;
            door_open_q    <= door_open_d;
            pending_q      <= pending_d;
            served_valid_q <= served_valid_d;
            served_floor_q <= served_floor_d;
            travel_q       <= travel_d;
            door_q         <= door_d;
        end
    end

    assign cur_floor    = cur_floor_q;
    assign dir          = dir_q;
    assign door_open    = door_open_q;
    assign pending      = pending_q;
    assign served_valid = served_valid_q;
    assign served_floor = served_floor_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// Directed bench for lift_car_controller (11 floors, 4-cycle floors, 8-cycle door).
module tb_lift_car_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_floor = '0;
    logic [10:0] car_call = '0;
    logic [3:0]  cur_floor;
    logic [1:0]  dir;
    logic        door_open;
    logic [10:0] pending;
    logic        served_valid;
    logic [3:0]  served_floor;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic bound_err = 1'b0;
    int   door_cycles;
    int   serve_cnt;

    lift_car_controller #(
        .NUM_FLOORS (11),
        .FLOOR_TIME (4),
        .DOOR_TIME  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .car_call     (car_call),
        .cur_floor    (cur_floor),
        .dir          (dir),
        .door_open    (door_open),
        .pending      (pending),
        .served_valid (served_valid),
        .served_floor (served_floor)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cur_floor > 4'd10) bound_err = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        car_call  = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic send_req(input logic [3:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_served(input string tag, input logic [3:0] exp_floor);
        int unsigned n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!served_valid && n < 400);
        check({tag, "_seen"}, served_valid, 1);
        check(tag, served_floor, exp_floor);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (!(dir == 2'b00 && !door_open && pending == '0) && n < 600) begin
            tick(1);
            n++;
        end
        check(tag, (dir == 2'b00 && !door_open && pending == '0), 1);
    endtask

    task automatic step();
        tick(1);
        if (door_open) door_cycles++;
        if (served_valid) serve_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        do_reset();
        check("rst_floor", cur_floor, 0);
        check("rst_dir", dir, 0);
        check("rst_door", door_open, 0);
        check("rst_pending", pending, 0);
        check("rst_served_v", served_valid, 0);
        check("rst_served_f", served_floor, 0);

        // Single request to floor 3: exact cycle timing.
        send_req(4'd3);
        check("t1_pend_e0", pending, 11'h008);
        check("t1_dir_e0", dir, 2'b00);
        tick(1);
        check("t1_dir_e1", dir, 2'b11);
        check("t1_floor_e1", cur_floor, 0);
        tick(11);
        check("t1_floor_e12", cur_floor, 2);
        check("t1_door_e12", door_open, 0);
        tick(1);
        check("t1_floor_e13", cur_floor, 3);
        check("t1_door_e13", door_open, 1);
        check("t1_sv_e13", served_valid, 1);
        check("t1_sf_e13", served_floor, 3);
        check("t1_pend_e13", pending, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!door_open) break;
            n++;
        end
        check("t1_door_cycles", n, 8);
        check("t1_dir_idle", dir, 2'b00);
        check("t1_pend_end", pending, 0);

        // Car call at 4 while heading to 8.
        do_reset();
        send_req(4'd8);
        tick(3);
        car_call = 11'h010;
        tick(1);
        car_call = '0;
        wait_served("t2_first", 4'd4);
        wait_served("t2_second", 4'd8);
        wait_idle("t2_idle");
        check("t2_floor", cur_floor, 8);

        // Up to 9, then reverse to 2.
        do_reset();
        send_req(4'd5);
        wait_idle("t3_to5");
        check("t3_at5", cur_floor, 5);
        send_req(4'd9);
        tick(1);
        check("t3_dir_up", dir, 2'b11);
        tick(5);
        send_req(4'd2);
        wait_served("t3_first", 4'd9);
        check("t3_dir_at9", dir, 2'b11);
        wait_served("t3_second", 4'd2);
        check("t3_dir_at2", dir, 2'b10);
        wait_idle("t3_idle");
        check("t3_dir_end", dir, 2'b00);
        check("t3_floor_end", cur_floor, 2);

        // Door at 6 extended twice by car_call[6].
        send_req(4'd6);
        wait_served("t4_enter", 4'd6);
        door_cycles = 1;
        serve_cnt   = 1;
        step();
        step();
        car_call = 11'h040;
        step();
        car_call = '0;
        step();
        step();
        step();
        car_call = 11'h040;
        step();
        car_call = '0;
        for (int i = 0; i < 40 && door_open; i++) step();
        check("t4_door_cycles", door_cycles, 15);
        check("t4_serve_cnt", serve_cnt, 3);
        check("t4_sf", served_floor, 6);
        check("t4_pend", pending, 0);
        check("t4_dir", dir, 2'b00);

        // Out-of-range assignments ignored; top floor accepted.
        send_req(4'd12);
        tick(3);
        check("t5_pend_12", pending, 0);
        check("t5_dir_12", dir, 2'b00);
        check("t5_door_12", door_open, 0);
        check("t5_floor_12", cur_floor, 6);
        send_req(4'd11);
        tick(2);
        check("t5_pend_11", pending, 0);
        send_req(4'd10);
        check("t5_pend_10", pending, 11'h400);

        // Asynchronous reset mid-travel.
        do_reset();
        send_req(4'd7);
        n = 0;
        while (cur_floor != 4'd2 && n < 100) begin
            tick(1);
            n++;
        end
        check("t6_reach2", cur_floor, 2);
        check("t6_pend7", pending, 11'h080);
        #2 rst = 1'b1;
        #1;
        check("t6_async_floor", cur_floor, 0);
        check("t6_async_dir", dir, 0);
        check("t6_async_pend", pending, 0);
        check("t6_async_door", door_open, 0);
        check("t6_async_sv", served_valid, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("t6_post_floor", cur_floor, 0);
        check("t6_post_dir", dir, 0);
        check("t6_post_pend", pending, 0);

        check("floor_bound", bound_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
